fifo_word_packer: RTL

Downstream drain stage for the 8-bit FIFO: pops bytes through the FIFO's `rd`/`empty`/`out` read port and packs them into BYTES_PER_WORD-byte words. Each packed word is presented on a valid/ready output port to the wide datapath. The block runs entirely in the FIFO read-clock domain and sits directly on the FIFO read side.

---
 rtl/fifo_pack_pkg.sv | 20 ++
 rtl/pack_flush_timer.sv | 29 ++
 rtl/fifo_word_packer.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO drain-side word packer.
package fifo_pack_pkg;

   typedef enum logic [1:0] {FILL, DRAIN, HOLD} pack_state_e;

   localparam int unsigned DEFAULT_BYTES_PER_WORD = 4;
   localparam int unsigned DEFAULT_FLUSH_CYCLES   = 16;
   localparam int unsigned MAX_LANES              = 64;

   // Low n bits set; callers cast down to their lane count.
   function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned n);
      logic [MAX_LANES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/pack_flush_timer.sv
// Saturating idle counter; expired holds once FLUSH_CYCLES idle cycles have elapsed.
module pack_flush_timer
   import fifo_pack_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned TW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [TW-1:0] LIMIT = TW'(FLUSH_CYCLES);

   logic [TW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (count_en && (cnt_q != LIMIT)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from the FIFO read port and presents them as packed words on valid/ready.
// Define PACK_FLUSH_EN to flush a partial word after FLUSH_CYCLES idle cycles.
module fifo_word_packer
   import fifo_pack_pkg::*;
#(
   parameter int unsigned BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD,
   parameter int unsigned FLUSH_CYCLES   = DEFAULT_FLUSH_CYCLES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  fifo_out,
   input  logic                        fifo_empty,
   output logic                        fifo_rd,
   output logic [8*BYTES_PER_WORD-1:0] word_data,
   output logic [BYTES_PER_WORD-1:0]   word_keep,
   output logic                        word_valid,
   input  logic                        word_ready
);

   localparam int unsigned CW = $clog2(BYTES_PER_WORD + 1);
   localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD);
   localparam logic [BYTES_PER_WORD-1:0] KEEP_FULL =
      BYTES_PER_WORD'(keep_mask(BYTES_PER_WORD));

   pack_state_e                          state_q;
   logic [CW-1:0]                        issued_q;
   logic [CW-1:0]                        lane_q;
   logic                                 rd_q;
   logic [BYTES_PER_WORD-1:0][7:0]       data_q;
   logic [BYTES_PER_WORD-1:0]            keep_q;
   logic                                 valid_q;
   logic                                 flush;

   assign fifo_rd = !rst && !fifo_empty && (state_q == FILL) && (issued_q < LAST);

`ifdef PACK_FLUSH_EN
   logic idle;
   logic flush_expired;

   assign idle = (state_q == FILL) && (issued_q != '0) && !fifo_rd && !rd_q;

   pack_flush_timer #(
      .FLUSH_CYCLES(FLUSH_CYCLES)
   ) u_flush_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!idle),
      .count_en(idle),
      .expired (flush_expired)
   );

   // A pop arriving on the expiry cycle wins; the word keeps filling.
   assign flush = flush_expired && !fifo_rd;
`else
   assign flush = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         issued_q <= '0;
         lane_q   <= '0;
         rd_q     <= 1'b0;
         data_q   <= '0;
         keep_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         rd_q <= fifo_rd;
         if (rd_q) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
               if (lane_q == CW'(i)) data_q[i] <= fifo_out;
            end
            lane_q <= lane_q + 1'b1;
         end
         case (state_q)
            FILL: begin
               if (fifo_rd) begin
                  issued_q <= issued_q + 1'b1;
                  if ((issued_q + 1'b1) == LAST) state_q <= DRAIN;
               end else if (flush) begin
                  state_q <= HOLD;
                  valid_q <= 1'b1;
                  keep_q  <= BYTES_PER_WORD'(keep_mask(32'(lane_q)));
               end
            end
            DRAIN: begin
               if (rd_q) begin
                  state_q <= HOLD;
                  valid_q <= 1'b1;
                  keep_q  <= KEEP_FULL;
               end
            end
            HOLD: begin
               if (word_ready) begin
                  state_q  <= FILL;
                  issued_q <= '0;
                  lane_q   <= '0;
                  data_q   <= '0;
                  keep_q   <= '0;
                  valid_q  <= 1'b0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign word_data  = data_q;
   assign word_keep  = keep_q;
   assign word_valid = valid_q;

endmodule
